ps2_mouse_tracker: RTL and testbench

// - Consumes 3-byte PS/2 mouse packets from ps2_top (ps2pkt_vld/ps2pkt_data).
// - Decodes buttons and signed deltas, accumulates a clamped absolute cursor position.
// - Presents position plus buttons to the bus/display side; counts malformed packets.
// - 2-stage pipeline, one clock domain (clk_sys); accepts a packet every cycle.

---
 rtl/ps2_mouse_if.sv | 28 ++
 rtl/ps2_mouse_tracker.sv | 118 +++++++++++
 tb/tb_ps2_mouse_tracker.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_if.sv
// PS/2 mouse tracker bus: packet strobe and recenter in,
// cursor position, buttons and error status out.
interface ps2_mouse_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           ps2pkt_vld;
  logic [23:0]    ps2pkt_data;
  logic           recenter;
  logic [X_W-1:0] mouse_x;
  logic [Y_W-1:0] mouse_y;
  logic [2:0]     mouse_btn;
  logic           pos_vld;
  logic           pkt_err;
  logic [7:0]     err_cnt;

  modport master (
    output ps2pkt_vld, ps2pkt_data, recenter,
    input  mouse_x, mouse_y, mouse_btn,
    input  pos_vld, pkt_err, err_cnt
  );

  modport slave (
    input  ps2pkt_vld, ps2pkt_data, recenter,
    output mouse_x, mouse_y, mouse_btn,
    output pos_vld, pkt_err, err_cnt
  );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet decoder with clamped absolute cursor.
// Stage 1 decodes the packet, stage 2 updates position.
module ps2_mouse_tracker #(
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int X_MAX      = 159,
  parameter int Y_MAX      = 119,
  parameter int X_INIT     = 80,
  parameter int Y_INIT     = 60,
  parameter int SENS_SHIFT = 0
) (
  input logic     clk_sys,
  input logic     rst_n,
  ps2_mouse_if.slave bus
);
  localparam int PW = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam logic signed [PW-1:0] XM = PW'(X_MAX);
  localparam logic signed [PW-1:0] YM = PW'(Y_MAX);

  logic              s1_vld;
  logic              s1_bad;
  logic [2:0]        s1_btn;
  logic signed [8:0] s1_dx;
  logic signed [8:0] s1_dy;

  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [2:0]     btn_q;
  logic           pv_q;
  logic           pe_q;
  logic [7:0]     ec_q;

  logic [23:0]       d;
  logic signed [8:0] dx_raw;
  logic signed [8:0] dy_raw;
  logic signed [8:0] dx_sh;
  logic signed [8:0] dy_sh;

  always_comb begin
    d      = bus.ps2pkt_data;
    dx_raw = d[6] ? '0 : {d[4], d[15:8]};
    dy_raw = d[7] ? '0 : {d[5], d[23:16]};
    dx_sh  = dx_raw >>> SENS_SHIFT;
    dy_sh  = dy_raw >>> SENS_SHIFT;
  end

  logic signed [PW-1:0] nx;
  logic signed [PW-1:0] ny;
  logic [X_W-1:0]       xn;
  logic [Y_W-1:0]       yn;

  // Wide signed math so over/underflow is visible before clamping
  always_comb begin
    nx = $signed({{(PW-X_W){1'b0}}, x_q})
       + $signed({{(PW-9){s1_dx[8]}}, s1_dx});
    ny = $signed({{(PW-Y_W){1'b0}}, y_q})
       - $signed({{(PW-9){s1_dy[8]}}, s1_dy});
    if (nx[PW-1])
      xn = '0;
    else if (nx > XM)
      xn = X_W'(X_MAX);
    else
      xn = nx[X_W-1:0];
    if (ny[PW-1])
      yn = '0;
    else if (ny > YM)
      yn = Y_W'(Y_MAX);
    else
      yn = ny[Y_W-1:0];
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_bad <= 1'b0;
      s1_btn <= '0;
      s1_dx  <= '0;
      s1_dy  <= '0;
      x_q    <= X_W'(X_INIT);
      y_q    <= Y_W'(Y_INIT);
      btn_q  <= '0;
      pv_q   <= 1'b0;
      pe_q   <= 1'b0;
      ec_q   <= '0;
    end else if (bus.recenter) begin
      // Drops both the packet in flight and the one arriving now
      s1_vld <= 1'b0;
      x_q    <= X_W'(X_INIT);
      y_q    <= Y_W'(Y_INIT);
      pv_q   <= 1'b1;
      pe_q   <= 1'b0;
    end else begin
      s1_vld <= bus.ps2pkt_vld;
      if (bus.ps2pkt_vld) begin
        s1_bad <= ~d[3];
        s1_btn <= d[2:0];
        s1_dx  <= dx_sh;
        s1_dy  <= dy_sh;
      end
      pv_q <= s1_vld & ~s1_bad;
      pe_q <= s1_vld & s1_bad;
      if (s1_vld && !s1_bad) begin
        x_q   <= xn;
        y_q   <= yn;
        btn_q <= s1_btn;
      end
      if (s1_vld && s1_bad && ec_q != 8'hFF)
        ec_q <= ec_q + 8'd1;
    end
  end

  assign bus.mouse_x   = x_q;
  assign bus.mouse_y   = y_q;
  assign bus.mouse_btn = btn_q;
  assign bus.pos_vld   = pv_q;
  assign bus.pkt_err   = pe_q;
  assign bus.err_cnt   = ec_q;
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: integer-level reference model
// checked every cycle, plus directed literal expectations.
module tb_ps2_mouse_tracker;
  localparam int XMX  = 159;
  localparam int YMX  = 119;
  localparam int SENS = 0;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;

  ps2_mouse_if #(.X_W(8), .Y_W(7)) bus ();

  ps2_mouse_tracker dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  always #10 clk_sys = ~clk_sys;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: one pending packet, integer arithmetic
  bit    m_ok   = 0;
  int    m_x, m_y, m_btn, m_err;
  bit    m_pv, m_pe;
  bit    m_pend;
  logic [23:0] m_pd;

  always @(posedge clk_sys) begin
    int dx, dy, nx, ny;
    if (!rst_n) begin
      m_ok <= 1; m_x <= 80; m_y <= 60; m_btn <= 0;
      m_err <= 0; m_pv <= 0; m_pe <= 0; m_pend <= 0;
    end else if (bus.recenter) begin
      m_x <= 80; m_y <= 60; m_pv <= 1; m_pe <= 0; m_pend <= 0;
    end else begin
      m_pv <= 0;
      m_pe <= 0;
      if (m_pend) begin
        if (!m_pd[3]) begin
          m_pe <= 1;
          if (m_err < 255) m_err <= m_err + 1;
        end else begin
          dx = m_pd[6] ? 0 : int'(m_pd[15:8]) - (m_pd[4] ? 256 : 0);
          dy = m_pd[7] ? 0 : int'(m_pd[23:16]) - (m_pd[5] ? 256 : 0);
          dx = dx >>> SENS;
          dy = dy >>> SENS;
          nx = m_x + dx;
          ny = m_y - dy;
          nx = nx < 0 ? 0 : (nx > XMX ? XMX : nx);
          ny = ny < 0 ? 0 : (ny > YMX ? YMX : ny);
          m_x <= nx; m_y <= ny; m_btn <= int'(m_pd[2:0]); m_pv <= 1;
        end
      end
      m_pend <= bus.ps2pkt_vld;
      m_pd   <= bus.ps2pkt_data;
    end
  end

  always @(negedge clk_sys) begin
    if (m_ok) begin
      n_chk++;
      if (int'(bus.mouse_x) != m_x || int'(bus.mouse_y) != m_y ||
          int'(bus.mouse_btn) != m_btn || bus.pos_vld != m_pv ||
          bus.pkt_err != m_pe || int'(bus.err_cnt) != m_err) begin
        n_fail++;
        $display("FAIL model @%0t: x=%0d y=%0d btn=%0d pv=%0b pe=%0b ec=%0d, expected x=%0d y=%0d btn=%0d pv=%0b pe=%0b ec=%0d",
                 $time, bus.mouse_x, bus.mouse_y, bus.mouse_btn,
                 bus.pos_vld, bus.pkt_err, bus.err_cnt,
                 m_x, m_y, m_btn, m_pv, m_pe, m_err);
      end
    end
  end

  // Drive one packet, return at the negedge where its result is visible
  task automatic send(input logic [23:0] dat);
    @(negedge clk_sys);
    bus.ps2pkt_vld  = 1'b1;
    bus.ps2pkt_data = dat;
    @(negedge clk_sys);
    bus.ps2pkt_vld  = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic recenter_now();
    @(negedge clk_sys);
    bus.recenter = 1'b1;
    @(negedge clk_sys);
    bus.recenter = 1'b0;
  endtask

  initial begin
    bus.ps2pkt_vld  = 1'b0;
    bus.ps2pkt_data = '0;
    bus.recenter    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("rst_x", int'(bus.mouse_x), 80);
    chk("rst_y", int'(bus.mouse_y), 60);
    chk("rst_btn", int'(bus.mouse_btn), 0);
    chk("rst_err", int'(bus.err_cnt), 0);
    chk("rst_pv", int'(bus.pos_vld), 0);
    rst_n = 1'b1;
    @(negedge clk_sys);

    // L=1, dx=+5, dy=-5 (Y sign in status bit5)
    send(24'hFB_05_29);
    chk("move_pv", int'(bus.pos_vld), 1);
    chk("move_x", int'(bus.mouse_x), 85);
    chk("move_y", int'(bus.mouse_y), 65);
    chk("move_btn", int'(bus.mouse_btn), 1);
    @(negedge clk_sys);
    chk("move_pv_drop", int'(bus.pos_vld), 0);

    send(24'h00_46_08);
    chk("x_155", int'(bus.mouse_x), 155);
    send(24'h00_0A_08);
    chk("clamp_xmax", int'(bus.mouse_x), 159);
    send(24'h3F_00_08);
    chk("y_2", int'(bus.mouse_y), 2);
    send(24'h0A_00_08);
    chk("clamp_y0", int'(bus.mouse_y), 0);

    recenter_now();
    chk("rc_x", int'(bus.mouse_x), 80);
    chk("rc_pv", int'(bus.pos_vld), 1);
    send(24'h00_80_18);
    chk("clamp_xneg", int'(bus.mouse_x), 0);
    chk("xneg_y", int'(bus.mouse_y), 60);

    send(24'h03_40_48);
    chk("ovf_x", int'(bus.mouse_x), 0);
    chk("ovf_y", int'(bus.mouse_y), 57);

    send(24'h00_00_0F);
    chk("zero_pv", int'(bus.pos_vld), 1);
    chk("zero_btn", int'(bus.mouse_btn), 7);

    send(24'h10_10_00);
    chk("err_pe", int'(bus.pkt_err), 1);
    chk("err_pv", int'(bus.pos_vld), 0);
    chk("err_cnt1", int'(bus.err_cnt), 1);
    chk("err_x", int'(bus.mouse_x), 0);
    chk("err_btn", int'(bus.mouse_btn), 7);

    @(negedge clk_sys);
    for (int i = 0; i < 300; i++) begin
      bus.ps2pkt_vld  = 1'b1;
      bus.ps2pkt_data = 24'h00_00_00;
      @(negedge clk_sys);
    end
    bus.ps2pkt_vld = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("err_sat", int'(bus.err_cnt), 255);

    recenter_now();
    bus.ps2pkt_vld  = 1'b1;
    bus.ps2pkt_data = 24'h00_01_08;
    @(negedge clk_sys);
    bus.ps2pkt_data = 24'h00_02_08;
    @(negedge clk_sys);
    bus.ps2pkt_data = 24'h00_03_08;
    chk("b2b_pv1", int'(bus.pos_vld), 1);
    chk("b2b_x1", int'(bus.mouse_x), 81);
    @(negedge clk_sys);
    bus.ps2pkt_vld = 1'b0;
    chk("b2b_pv2", int'(bus.pos_vld), 1);
    chk("b2b_x2", int'(bus.mouse_x), 83);
    @(negedge clk_sys);
    chk("b2b_pv3", int'(bus.pos_vld), 1);
    chk("b2b_x3", int'(bus.mouse_x), 86);
    @(negedge clk_sys);
    chk("b2b_end", int'(bus.pos_vld), 0);

    bus.recenter    = 1'b1;
    bus.ps2pkt_vld  = 1'b1;
    bus.ps2pkt_data = 24'h00_07_08;
    @(negedge clk_sys);
    bus.recenter   = 1'b0;
    bus.ps2pkt_vld = 1'b0;
    chk("rcv_x", int'(bus.mouse_x), 80);
    chk("rcv_y", int'(bus.mouse_y), 60);
    chk("rcv_pv", int'(bus.pos_vld), 1);
    repeat (2) @(negedge clk_sys);
    chk("rcv_drop_pv", int'(bus.pos_vld), 0);
    chk("rcv_drop_x", int'(bus.mouse_x), 80);

    // Recenter while a packet sits in stage 1
    bus.ps2pkt_vld  = 1'b1;
    bus.ps2pkt_data = 24'h00_09_08;
    @(negedge clk_sys);
    bus.ps2pkt_vld = 1'b0;
    bus.recenter   = 1'b1;
    @(negedge clk_sys);
    bus.recenter = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("rc_s1_x", int'(bus.mouse_x), 80);

    // Reset with a packet in flight
    bus.ps2pkt_vld  = 1'b1;
    bus.ps2pkt_data = 24'h00_05_0A;
    @(negedge clk_sys);
    bus.ps2pkt_vld = 1'b0;
    rst_n = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("rst_fl_x", int'(bus.mouse_x), 80);
    chk("rst_fl_ec", int'(bus.err_cnt), 0);
    chk("rst_fl_btn", int'(bus.mouse_btn), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
